bus_rr_sched: RTL and testbench
===============================

// Module: bus_rr_sched
// PURPOSE
//  Round-robin scheduler for the shared packet bus between the driver FIFOs and the agents' input FIFOs.
//  Picks one pending driver, pops its head packet and decodes the 8-bit destination ID (MSBs).
//  Pushes the packet to the destination, or to every other driver when the ID is broadcast.
//  Adds per-grant burst limiting, destination backpressure and invalid-ID drop counting.
// PARAMETERS
//  drvrs      16     number of drivers/agents on the bus (2..256)
//  pckg_sz    16     packet width in bits; [pckg_sz-1 -: 8] = destination ID
//  broadcast  8'hFF  destination ID meaning "all drivers except source"
//  max_burst  4      max packets moved per grant before priority rotates (>=1)
// PORTS
//  clk       in   1               bus clock, rising edge
//  reset     in   1               synchronous, active-high
//  pndng     in   drvrs           driver i FIFO non-empty
//  D_pop     in   drvrs*pckg_sz   driver i head packet at [i*pckg_sz +: pckg_sz]
//  full      in   drvrs           agent i input FIFO full (no push allowed)
//  pop       out  drvrs           one-hot pop strobe to granted driver
//  push      out  drvrs           push strobe(s) to destination agent(s)
//  D_push    out  pckg_sz         bus data, valid while any push bit is high
//  grant_id  out  $clog2(drvrs)   currently granted driver
//  busy      out  1               high in any state except IDLE
//  drop_cnt  out  16              dropped-packet count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: pop=0, push=0, D_push=0, grant_id=0, busy=0, drop_cnt=0, state=IDLE.
//   Rotation pointer=0, burst count=0. Reset also aborts mid-transfer; the held packet is discarded.
//  FSM states: IDLE, POP, XFER, TURN. Outputs are decoded from registered state/data only.
//  IDLE: if |pndng, register the winner.
//   Winner = first i with pndng[i], searched ptr, ptr+1, ... drvrs-1, 0, ... (wraps).
//   Next state POP; otherwise stay in IDLE.
//  POP (1 cycle): pop[grant_id]=1. On the same edge, capture D_pop slice into the data register. Next state XFER.
//  XFER: dest = data[pckg_sz-1 -: 8]. Build the target mask:
//   dest<drvrs and dest!=grant_id -> one-hot(dest).
//   dest==broadcast -> all ones with bit grant_id cleared.
//   anything else -> invalid: no push; drop_cnt+1 (saturating); treat the packet as done.
//  Stall: if (mask & full)!=0, hold in XFER with push=0. Data and mask stay stable. No timeout.
//  Delivery: when not stalled, push=mask for exactly 1 cycle and D_push=data. Burst count +1.
//  After a done packet (delivered or dropped):
//   pndng[grant_id] && burst<max_burst -> POP (same driver).
//   otherwise -> TURN.
//  TURN (1 cycle): ptr=grant_id+1 mod drvrs, burst=0, next IDLE. Guarantees one bubble between grants.
//  Latency, idle bus: pndng high at edge k -> pop in cycle k+1 -> push in cycle k+2 -> TURN in k+3.
//   Burst throughput is 1 packet per 2 cycles.
//  pndng changes on non-granted drivers during a grant are ignored until the next IDLE.
//  pop never asserts with pndng[grant_id]=0; push and pop are never high in the same cycle.
//  D_push holds its last value when push=0. Only the pushed cycle is meaningful.
// TESTING
//  1 Single: pndng[3]=1, D_pop[3]=16'h05AB -> pop=16'h0008 one cycle.
//     Next cycle push=16'h0020, D_push=16'h05AB. drop_cnt=0.
//  2 Fairness, max_burst=1: drivers 0,1,2 always pending, each packet to driver 5.
//     -> grant_id sequence 0,1,2,0,1,2. No driver granted twice in a row.
//  3 Burst: driver 7 holds 6 packets, driver 1 pending, max_burst=4.
//     -> 4 pushes from 7, TURN, 1 push from 1, then 7 again.
//  4 Broadcast: driver 2 sends 16'hFF12 with full[9]=1 for 10 cycles -> push=0 while full[9]=1.
//     Then push=16'hFFFB for one cycle, D_push=16'hFF12.
//  5 Invalid/self: packets 16'h2000 (dest 32) and 16'h0400 from driver 4.
//     -> no push, drop_cnt=2, scheduler returns to IDLE.
//  6 Reset mid-stall: hold full[5]=1 in XFER, pulse reset for 1 cycle.
//     -> all outputs 0 next cycle, state IDLE, next grant searched from driver 0.

Source files
------------

// File: rtl/bus_rr_sched.sv
// Round-robin packet bus scheduler: pops one driver at a time,
// decodes the destination and pushes unicast or broadcast.
module bus_rr_sched #(
  parameter int          drvrs     = 16,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF,
  parameter int          max_burst = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  input  logic [drvrs-1:0]           full,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic [$clog2(drvrs)-1:0]   grant_id,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);

  localparam int GW = $clog2(drvrs);
  localparam int BW = $clog2(max_burst + 1);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    XFER,
    TURN
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic [pckg_sz-1:0]   data_q, data_d;
  logic [drvrs-1:0]     mask_q, mask_d;
  logic [drvrs-1:0]     pop_q, pop_d;
  logic [drvrs-1:0]     push_q, push_d;
  logic                 done_q, done_d;
  logic [15:0]          drop_q, drop_d;

  logic [GW-1:0]        win_id;
  logic [pckg_sz-1:0]   pop_pkt;
  logic [drvrs-1:0]     pop_mask;
  logic [drvrs-1:0]     cur_mask;
  logic                 eval;

  // First requester at or after start, wrapping around.
  function automatic logic [GW-1:0] rr_pick(
    input logic [drvrs-1:0] req,
    input logic [GW-1:0]    start
  );
    logic found;
    int   idx;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < drvrs; k++) begin
      idx = int'(start) + k;
      if (idx >= drvrs) idx = idx - drvrs;
      if (!found && req[idx]) begin
        found   = 1'b1;
        rr_pick = GW'(idx);
      end
    end
  endfunction

  function automatic logic [drvrs-1:0] onehot(
    input logic [GW-1:0] idx
  );
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Empty mask means the packet is undeliverable and gets dropped.
  function automatic logic [drvrs-1:0] dest_mask(
    input logic [pckg_sz-1:0] pkt,
    input logic [GW-1:0]      src
  );
    logic [7:0] dest;
    dest      = pkt[pckg_sz-1 -: 8];
    dest_mask = '0;
    if (dest == broadcast) begin
      dest_mask      = '1;
      dest_mask[src] = 1'b0;
    end else if (int'(dest) < drvrs && dest[GW-1:0] != src) begin
      dest_mask[dest[GW-1:0]] = 1'b1;
    end
  endfunction

  assign win_id   = rr_pick(pndng, ptr_q);
  assign pop_pkt  = D_pop[int'(grant_q)*pckg_sz +: pckg_sz];
  assign pop_mask = dest_mask(pop_pkt, grant_q);

  // Next-state logic for the grant FSM and its registered outputs.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    burst_d  = burst_q;
    data_d   = data_q;
    mask_d   = mask_q;
    pop_d    = '0;
    push_d   = '0;
    done_d   = done_q;
    drop_d   = drop_q;
    cur_mask = mask_q;
    eval     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pndng) begin
          grant_d = win_id;
          pop_d   = onehot(win_id);
          state_d = POP;
        end
      end
      POP: begin
        data_d   = pop_pkt;
        mask_d   = pop_mask;
        cur_mask = pop_mask;
        done_d   = 1'b0;
        eval     = 1'b1;
        state_d  = XFER;
      end
      XFER: begin
        if (done_q) begin
          done_d = 1'b0;
          if (pndng[grant_q] && burst_q < BW'(max_burst)) begin
            pop_d   = onehot(grant_q);
            state_d = POP;
          end else begin
            state_d = TURN;
          end
        end else begin
          eval = 1'b1;
        end
      end
      TURN: begin
        ptr_d   = (int'(grant_q) == drvrs - 1) ? '0
                                               : grant_q + GW'(1);
        burst_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (eval) begin
      if (cur_mask == '0) begin
        done_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end else if ((cur_mask & full) == '0) begin
        push_d  = cur_mask;
        done_d  = 1'b1;
        burst_d = burst_q + BW'(1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      pop_q   <= '0;
      push_q  <= '0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_rr_sched.sv
// Directed bench for bus_rr_sched: single, fairness, burst,
// broadcast stall, drops and reset mid-stall.
module tb_bus_rr_sched;

  localparam int N = 16;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_a, reset_b;
  logic [N-1:0]     pndng_a, full_a, pop_a, push_a;
  logic [N*W-1:0]   dpop_a;
  logic [W-1:0]     dpush_a;
  logic [3:0]       gid_a;
  logic             busy_a;
  logic [15:0]      drop_a;

  logic [N-1:0]     pndng_b, full_b, pop_b, push_b;
  logic [N*W-1:0]   dpop_b;
  logic [W-1:0]     dpush_b;
  logic [3:0]       gid_b;
  logic             busy_b;
  logic [15:0]      drop_b;

  bus_rr_sched #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF),
                 .max_burst(4)) u_a (
    .clk(clk), .reset(reset_a), .pndng(pndng_a), .D_pop(dpop_a),
    .full(full_a), .pop(pop_a), .push(push_a), .D_push(dpush_a),
    .grant_id(gid_a), .busy(busy_a), .drop_cnt(drop_a)
  );

  bus_rr_sched #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF),
                 .max_burst(1)) u_b (
    .clk(clk), .reset(reset_b), .pndng(pndng_b), .D_pop(dpop_b),
    .full(full_b), .pop(pop_b), .push(push_b), .D_push(dpush_b),
    .grant_id(gid_b), .busy(busy_b), .drop_cnt(drop_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver FIFO model for instance a.
  logic [W-1:0] fifo [N][8];
  int           head [N];
  int           tail [N];
  bit           pend_v = 1'b0;
  int           pend_i = 0;
  int           n_ovl  = 0;
  int           eg [$];
  logic [15:0]  em [$];
  logic [15:0]  ed [$];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      pndng_a[i]          = (head[i] != tail[i]);
      dpop_a[i*W +: W]    = fifo[i][head[i] % 8];
    end
  endtask

  task automatic load(input int i, input logic [W-1:0] v);
    fifo[i][tail[i] % 8] = v;
    tail[i]++;
  endtask

  task automatic cyc();
    @(negedge clk);
    if ((pop_a & push_a) != '0) n_ovl++;
    if (push_a != '0) begin
      eg.push_back(int'(gid_a));
      em.push_back(push_a);
      ed.push_back(dpush_a);
    end
    if (pend_v) head[pend_i]++;
    pend_v = 1'b0;
    if (pop_a != '0) begin
      pend_v = 1'b1;
      pend_i = int'(gid_a);
    end
    drive();
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (busy_a && n < bound);
    chk(tag, busy_a, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pop"},  pop_a,   0);
    chk({tag, "_push"}, push_a,  0);
    chk({tag, "_dpush"}, dpush_a, 0);
    chk({tag, "_gid"},  gid_a,   0);
    chk({tag, "_busy"}, busy_a,  0);
    chk({tag, "_drop"}, drop_a,  0);
  endtask

  int exp_g3 [7] = '{7, 7, 7, 7, 1, 7, 7};
  int exp_g2 [6] = '{0, 1, 2, 0, 1, 2};
  int gq [$];
  int n;
  int pushes_b;

  initial begin
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      for (int j = 0; j < 8; j++) fifo[i][j] = '0;
    end
    reset_a = 1'b1;
    reset_b = 1'b1;
    full_a  = '0;
    full_b  = '0;
    pndng_b = '0;
    dpop_b  = '0;
    drive();
    repeat (3) cyc();
    chk_reset("rst");
    reset_a = 1'b0;

    // Single packet, exact latency.
    load(3, 16'h05AB);
    drive();
    cyc();
    chk("t1_pop", pop_a, 16'h0008);
    chk("t1_push0", push_a, 0);
    cyc();
    chk("t1_push", push_a, 16'h0020);
    chk("t1_dpush", dpush_a, 16'h05AB);
    chk("t1_pop0", pop_a, 0);
    chk("t1_drop", drop_a, 0);
    wait_idle("t1_idle", 10);

    // Burst limiting with a competing requester.
    eg.delete(); em.delete(); ed.delete();
    for (int k = 0; k < 6; k++) load(7, 16'h0070 + W'(k));
    load(1, 16'h0211);
    drive();
    n = 0;
    do begin
      cyc();
      n++;
    end while ((busy_a || pndng_a != '0) && n < 80);
    chk("t3_count", eg.size(), 7);
    for (int k = 0; k < 7; k++) begin
      if (k < eg.size()) chk($sformatf("t3_gid%0d", k), eg[k], exp_g3[k]);
    end
    if (eg.size() == 7) begin
      chk("t3_mask4", em[4], 16'h0004);
      chk("t3_data4", ed[4], 16'h0211);
      chk("t3_mask6", em[6], 16'h0001);
      chk("t3_data6", ed[6], 16'h0075);
    end

    // Broadcast held off by a full destination.
    eg.delete(); em.delete(); ed.delete();
    full_a = 16'h0200;
    load(2, 16'hFF12);
    drive();
    repeat (10) cyc();
    chk("t4_stall_push", eg.size(), 0);
    chk("t4_stall_busy", busy_a, 1);
    chk("t4_stall_gid", gid_a, 2);
    full_a = '0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (push_a == '0 && n < 6);
    chk("t4_push", push_a, 16'hFFFB);
    chk("t4_dpush", dpush_a, 16'hFF12);
    cyc();
    chk("t4_push_once", push_a, 0);
    wait_idle("t4_idle", 10);

    // Out-of-range and self-addressed packets are dropped.
    eg.delete(); em.delete(); ed.delete();
    load(4, 16'h2000);
    load(4, 16'h0400);
    drive();
    wait_idle("t5_idle", 20);
    chk("t5_drop", drop_a, 2);
    chk("t5_nopush", eg.size(), 0);

    // Reset while stalled in transfer.
    eg.delete(); em.delete(); ed.delete();
    full_a = 16'h0020;
    load(6, 16'h0500);
    drive();
    repeat (6) cyc();
    chk("t6_stall_busy", busy_a, 1);
    chk("t6_stall_push", eg.size(), 0);
    reset_a = 1'b1;
    cyc();
    chk_reset("t6_rst");
    reset_a = 1'b0;
    full_a  = '0;
    load(9, 16'h0300);
    load(1, 16'h0300);
    drive();
    n = 0;
    do begin
      cyc();
      n++;
    end while (pop_a == '0 && n < 6);
    chk("t6_gid", gid_a, 1);
    chk("t6_pop", pop_a, 16'h0002);
    wait_idle("t6_idle", 40);
    chk("ovl_a", n_ovl, 0);

    // Fairness with single-packet bursts on instance b.
    @(negedge clk);
    pndng_b = 16'h0007;
    for (int i = 0; i < 3; i++) dpop_b[i*W +: W] = 16'h0500;
    reset_b  = 1'b0;
    pushes_b = 0;
    for (int c = 0; c < 60 && gq.size() < 6; c++) begin
      @(negedge clk);
      if (pop_b != '0) gq.push_back(int'(gid_b));
      if (push_b != '0) begin
        pushes_b++;
        if (pushes_b == 1) chk("t2_push", push_b, 16'h0020);
      end
    end
    chk("t2_count", gq.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < gq.size()) chk($sformatf("t2_gid%0d", k), gq[k], exp_g2[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
